// File: rtl/pwm_fade.sv
// Duty-cycle ramp generator feeding the pwm block: steps duty_cycle toward a latched target.
// Optional CLAMP_PERIOD_EN adds a live period input that bounds both the target and duty_cycle.
module pwm_fade #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      start,
    input  logic [WIDTH-1:0]          target,
    input  logic [WIDTH-1:0]          step,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
`ifdef CLAMP_PERIOD_EN
    input  logic [WIDTH-1:0]          period,
`endif
    output logic [WIDTH-1:0]          duty_cycle,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic {S_IDLE, S_RAMP} state_t;

    state_t                    r_state;
    logic [WIDTH-1:0]          r_duty;
    logic [WIDTH-1:0]          r_target;
    logic [WIDTH-1:0]          r_step;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic                      r_busy;
    logic                      r_done;

    logic [WIDTH-1:0] w_new_tgt;
    logic [WIDTH-1:0] w_cur_tgt;
    logic [WIDTH-1:0] w_dist;
    logic             w_up;
    logic             w_tick;
    logic             w_land;
    logic [WIDTH-1:0] w_duty_d;
    logic [WIDTH-1:0] w_duty_q;

`ifdef CLAMP_PERIOD_EN
    // The ramp aims at the latched target re-clamped to the live period, so a
    // lowered period mid-ramp still lets the ramp terminate.
    assign w_new_tgt = (target < period) ? target : period;
    assign w_cur_tgt = (r_target < period) ? r_target : period;
    assign w_duty_q  = (w_duty_d > period) ? period : w_duty_d;
`else
    assign w_new_tgt = target;
    assign w_cur_tgt = r_target;
    assign w_duty_q  = w_duty_d;
`endif

    assign w_up   = (w_cur_tgt > r_duty);
    assign w_dist = w_up ? (w_cur_tgt - r_duty) : (r_duty - w_cur_tgt);
    assign w_tick = (r_state == S_RAMP) && (r_cnt == r_prescale);
    assign w_land = (w_dist <= r_step);

    always_comb begin
        w_duty_d = r_duty;
        if (en) begin
            if (start) begin
                if (step == '0)
                    w_duty_d = w_new_tgt;
            end else if (w_tick) begin
                if (w_land)
                    w_duty_d = w_cur_tgt;
                else if (w_up)
                    w_duty_d = r_duty + r_step;
                else
                    w_duty_d = r_duty - r_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_duty     <= '0;
            r_target   <= '0;
            r_step     <= '0;
            r_prescale <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_duty <= w_duty_q;
            if (!en) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else if (start) begin
                r_target   <= w_new_tgt;
                r_step     <= step;
                r_prescale <= prescale;
                r_cnt      <= '0;
                if (w_new_tgt == r_duty || step == '0) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_RAMP;
                    r_busy  <= 1'b1;
                end
            end else if (r_state == S_RAMP) begin
                if (w_tick) begin
                    r_cnt <= '0;
                    if (w_land) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign duty_cycle = r_duty;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_pwm_fade.sv
// Directed self-checking bench for pwm_fade; clamp scenarios are built when CLAMP_PERIOD_EN is defined.
module tb_pwm_fade;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned PW    = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic             start;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] step;
    logic [PW-1:0]    prescale;
`ifdef CLAMP_PERIOD_EN
    logic [WIDTH-1:0] period;
`endif
    logic [WIDTH-1:0] duty_cycle;
    logic             busy;
    logic             done;

    int unsigned n_checks;
    int unsigned n_errors;

    pwm_fade #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .target     (target),
        .step       (step),
        .prescale   (prescale),
`ifdef CLAMP_PERIOD_EN
        .period     (period),
`endif
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [WIDTH-1:0] d, input logic b, input logic dn);
        check({tag, ".duty"}, duty_cycle, d);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, ".done"}, {31'd0, done}, {31'd0, dn});
    endtask

    task automatic do_start(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] s, input logic [PW-1:0] p);
        target   = t;
        step     = s;
        prescale = p;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    logic [WIDTH-1:0] up_duty [8];
    logic             up_busy [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        en       = 1'b0;
        start    = 1'b0;
        target   = '0;
        step     = '0;
        prescale = '0;
`ifdef CLAMP_PERIOD_EN
        period   = '1;
`endif
        #1;

        // Reset hold and idle after release
        for (int i = 0; i < 3; i++) tick();
        chk3("reset", 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk3("idle", 32'd0, 1'b0, 1'b0);

        // Up ramp: 0 -> 10, step 3, prescale 1
        up_duty = '{32'd0, 32'd3, 32'd3, 32'd6, 32'd6, 32'd9, 32'd9, 32'd10};
        up_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_start(32'd10, 32'd3, 16'd1);
        chk3("up.e0", 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk3($sformatf("up.e%0d", i + 1), up_duty[i], up_busy[i], (i == 7));
        end
        tick();
        chk3("up.after", 32'd10, 1'b0, 1'b0);

        // Down ramp with exact landing: 10 -> 2, step 4, prescale 0
        do_start(32'd2, 32'd4, 16'd0);
        chk3("dn.e0", 32'd10, 1'b1, 1'b0);
        tick();
        chk3("dn.e1", 32'd6, 1'b1, 1'b0);
        tick();
        chk3("dn.e2", 32'd2, 1'b0, 1'b1);
        tick();
        chk3("dn.e3", 32'd2, 1'b0, 1'b0);

        // step==0 jumps straight to target
        do_start(32'h12345678, 32'd0, 16'd3);
        chk3("jump.e0", 32'h12345678, 1'b0, 1'b1);
        tick();
        chk3("jump.e1", 32'h12345678, 1'b0, 1'b0);

        // target equal to current duty: done only
        do_start(32'h12345678, 32'd5, 16'd0);
        chk3("eq.e0", 32'h12345678, 1'b0, 1'b1);
        tick();
        chk3("eq.e1", 32'h12345678, 1'b0, 1'b0);

        // Retarget mid-ramp at duty 6 toward 0
        do_start(32'd0, 32'd0, 16'd0);
        check("rt.zero", duty_cycle, 32'd0);
        tick();
        do_start(32'd10, 32'd3, 16'd0);
        tick();
        tick();
        chk3("rt.pre", 32'd6, 1'b1, 1'b0);
        do_start(32'd0, 32'd2, 16'd0);
        chk3("rt.e0", 32'd6, 1'b1, 1'b0);
        tick();
        chk3("rt.e1", 32'd4, 1'b1, 1'b0);
        tick();
        chk3("rt.e2", 32'd2, 1'b1, 1'b0);
        tick();
        chk3("rt.e3", 32'd0, 1'b0, 1'b1);
        tick();

        // Abort with en=0: duty holds, no done, start ignored
        do_start(32'd10, 32'd3, 16'd0);
        tick();
        check("ab.pre", duty_cycle, 32'd3);
        en = 1'b0;
        tick();
        chk3("ab.e0", 32'd3, 1'b0, 1'b0);
        do_start(32'd100, 32'd0, 16'd0);
        tick();
        chk3("ab.ign", 32'd3, 1'b0, 1'b0);
        en = 1'b1;

        // Reset mid-ramp
        do_start(32'd100, 32'd1, 16'd0);
        tick();
        check("rr.pre", duty_cycle, 32'd4);
        rst = 1'b0;
        tick();
        chk3("rr.e0", 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

`ifdef CLAMP_PERIOD_EN
        // Clamped target: period 5, target 10, step 2
        period = 32'd5;
        do_start(32'd10, 32'd2, 16'd0);
        chk3("cl.e0", 32'd0, 1'b1, 1'b0);
        tick();
        chk3("cl.e1", 32'd2, 1'b1, 1'b0);
        tick();
        chk3("cl.e2", 32'd4, 1'b1, 1'b0);
        tick();
        chk3("cl.e3", 32'd5, 1'b0, 1'b1);

        // Period lowered mid-ramp at duty 4
        rst = 1'b0;
        tick();
        rst    = 1'b1;
        period = 32'd20;
        do_start(32'd10, 32'd2, 16'd0);
        tick();
        tick();
        check("clp.pre", duty_cycle, 32'd4);
        period = 32'd3;
        tick();
        check("clp.e0", duty_cycle, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_fade.md
Name: pwm_fade

Overview:
Duty-cycle ramp generator that sits directly upstream of the pwm block. It drives pwm.duty_cycle from a GPMC-written target, stepping from the current duty toward the target by a fixed step every programmable number of clocks. This gives smooth LED/motor fades without host involvement. It runs in the pwm clock domain; register-file inputs are quasi-static and are latched on start.

Parameters:
WIDTH, 32, width of duty_cycle, target, step (and period when CLAMP_PERIOD_EN is defined)
PRESCALE_WIDTH, 16, width of the prescale interval counter

Ports:
clk  input  1  block clock (pwm clock domain)
rst  input  1  synchronous active-low reset; rst=0 at a rising clk edge resets the block
en  input  1  block enable; low aborts any ramp and holds duty_cycle
start  input  1  single-cycle pulse: latch target/step/prescale and begin ramp
target  input  WIDTH  destination duty value
step  input  WIDTH  magnitude of each increment or decrement
prescale  input  PRESCALE_WIDTH  step interval = prescale+1 clk cycles
duty_cycle  output  WIDTH  registered duty value to pwm
busy  output  1  high while in RAMP
done  output  1  one-cycle pulse when duty_cycle reaches target

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, duty_cycle=0, busy=0, done=0, interval counter=0, latched registers=0.
- States are IDLE and RAMP. The block is fully synchronous; all outputs are registered.
- IDLE, start=1 and en=1:
  - Latch target, step and prescale; clear the counter.
  - If target==duty_cycle: stay in IDLE and pulse done on the next edge; busy stays 0.
  - Else if step==0: duty_cycle<=target, pulse done, stay in IDLE.
  - Else: enter RAMP; busy=1 from the next edge.
- RAMP:
  - The counter increments each clk. When counter==latched prescale, a tick occurs and the counter resets to 0.
  - The first duty update is visible prescale+1 cycles after busy rises.
- On each tick, with d = |target - duty_cycle| as an unsigned WIDTH-bit compare:
  - If d <= step: duty_cycle<=target, busy<=0, done<=1 (same edge), next state IDLE.
  - Else duty_cycle <= duty_cycle + step (target above) or duty_cycle - step (target below).
  - Overflow and underflow cannot occur because of the d <= step check. No wrap-around is ever produced.
- start while busy (retarget): re-latch target, step and prescale; clear the counter; keep the current duty_cycle; direction is re-evaluated. start has priority over a coincident tick.
- en=0: return to IDLE, busy=0, no done, duty_cycle holds its value. start is ignored while en=0.
- Reset mid-ramp: immediate return to reset values on that edge.
- done is never high for more than one consecutive cycle, except on back-to-back starts that are each already complete.
- prescale=0 gives one step per clk.

Optional Feature:
CLAMP_PERIOD_EN.
- Defined: adds input period [WIDTH]. The latched target is min(target, period), and every registered duty_cycle value is additionally clamped to the live period input. If period drops below duty_cycle mid-ramp, duty_cycle<=period on the next edge and the ramp continues toward the clamped target.
- Not defined: no period port; target is used unmodified.

Test Plan:
- Reset hold: rst=0 for 3 clks -> duty_cycle=0, busy=0, done=0; release, no start -> all outputs stay 0.
- Up ramp: start with target=10, step=3, prescale=1 from duty 0 -> duty goes 3,6,9,10 at 2-clk intervals; done pulses on the edge that writes 10; busy falls on the same edge.
- Down ramp with exact landing: from duty=10, target=2, step=4, prescale=0 -> duty goes 6,2 on consecutive clks; done once.
- Edge cases: step=0, target=0x12345678 -> duty_cycle jumps next clk, done=1, busy never 1. Start with target==duty -> done only.
- Retarget and abort:
  - Mid-ramp at duty=6 (target 10), start with target=0, step=2 -> duty descends 4,2,0.
  - Separate run: en=0 mid-ramp -> duty holds, busy=0, no done.
- Clamp (CLAMP_PERIOD_EN): period=5, target=10, step=2 -> duty goes 2,4,5, then done.
- Clamp, period lowered: at duty=4, drive period to 3 -> duty=3 next edge.
